// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with a per-register
// pending-write scoreboard.
//
// Reads are registered (one cycle from address to data) and forward a
// same-cycle write. The scoreboard marks registers whose result is still in
// flight. A read that touches one of them raises `hazard` and is not taken.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   w_en       write enable
//   w_addr     write destination
//   w_in       write data
//   rd_en      read request; both read ports are sampled this cycle
//   rd0_addr   read port 0 source
//   rd1_addr   read port 1 source
//   lock_en    mark lock_addr as pending
//   lock_addr  register to lock
//   op0, op1   registered read data
//   op_valid   op0/op1 were loaded by a hazard-free read on the previous edge
//   hazard     combinational; the current read request hits a pending register
//   pending    scoreboard, bit i = register i pending
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic [WIDTH-1:0]  op0,
  output logic [WIDTH-1:0]  op1,
  output logic              op_valid,
  output logic              hazard,
  output logic [DEPTH-1:0]  pending
);

  if ((DEPTH < 2) || (DEPTH > (1 << ADDR_W))) begin : g_bad_params
    $error("regfile_sb: DEPTH must be in 2..2**ADDR_W");
  end

  // An address is legal when it names a real register that is not the
  // hardwired zero register.
  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0] regs [DEPTH];

  logic             wr_ok;
  logic             lock_ok;
  logic             fwd0, fwd1;
  logic             hz0, hz1;
  logic [WIDTH-1:0] rd0_val, rd1_val;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ok   = w_en && is_legal(w_addr);
    lock_ok = lock_en && is_legal(lock_addr);
    fwd0    = wr_ok && (w_addr == rd0_addr);
    fwd1    = wr_ok && (w_addr == rd1_addr);
    rd0_val = '0;
    rd1_val = '0;
    hz0     = 1'b0;
    hz1     = 1'b0;

    if (is_legal(rd0_addr)) begin
      rd0_val = fwd0 ? w_in : regs[rd0_addr];
      // A write landing this cycle delivers the awaited result, so it clears
      // the hazard as well as supplying the data.
      hz0     = pending[rd0_addr] && !fwd0;
    end
    if (is_legal(rd1_addr)) begin
      rd1_val = fwd1 ? w_in : regs[rd1_addr];
      hz1     = pending[rd1_addr] && !fwd1;
    end

    hazard = rd_en && (hz0 || hz1);
  end

  // NOTE: the register array has to come up as zero, so it is reset like any
  // other state; this rules out a RAM macro but keeps reads deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block order.
      regs[w_addr] <= w_in;
    end
  end

  // Scoreboard. The lock assignment comes second so that a lock and a write
  // to the same register on one edge leave it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (wr_ok)   pending[w_addr]    <= 1'b0;
      if (lock_ok) pending[lock_addr] <= 1'b1;
    end
  end

  // Output registers hold their data whenever the read is not taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op0      <= '0;
      op1      <= '0;
      op_valid <= 1'b0;
    end else if (rd_en && !hazard) begin
      op0      <= rd0_val;
      op1      <= rd1_val;
      op_valid <= 1'b1;
    end else begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Instance `dut` uses the default
// parameters (8x16, no zero register). Instance `zdut` uses DEPTH=6 with a
// hardwired zero register. Inputs change 1 ns after a rising edge and
// outputs are sampled there as well.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;

  // default instance
  logic        w_en, rd_en, lock_en;
  logic [2:0]  w_addr, rd0_addr, rd1_addr, lock_addr;
  logic [15:0] w_in;
  logic [15:0] op0, op1;
  logic        op_valid, hazard;
  logic [7:0]  pending;

  // ZERO_REG=1, DEPTH=6 instance
  logic        z_w_en, z_rd_en, z_lock_en;
  logic [2:0]  z_w_addr, z_rd0_addr, z_rd1_addr, z_lock_addr;
  logic [15:0] z_w_in;
  logic [15:0] z_op0, z_op1;
  logic        z_op_valid, z_hazard;
  logic [5:0]  z_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .w_en(w_en), .w_addr(w_addr), .w_in(w_in),
    .rd_en(rd_en), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .op0(op0), .op1(op1), .op_valid(op_valid),
    .hazard(hazard), .pending(pending)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1)) zdut (
    .clk(clk), .reset(reset),
    .w_en(z_w_en), .w_addr(z_w_addr), .w_in(z_w_in),
    .rd_en(z_rd_en), .rd0_addr(z_rd0_addr), .rd1_addr(z_rd1_addr),
    .lock_en(z_lock_en), .lock_addr(z_lock_addr),
    .op0(z_op0), .op1(z_op1), .op_valid(z_op_valid),
    .hazard(z_hazard), .pending(z_pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en = 1'b0; rd_en = 1'b0; lock_en = 1'b0;
    w_addr = '0; rd0_addr = '0; rd1_addr = '0; lock_addr = '0; w_in = '0;
    z_w_en = 1'b0; z_rd_en = 1'b0; z_lock_en = 1'b0;
    z_w_addr = '0; z_rd0_addr = '0; z_rd1_addr = '0; z_lock_addr = '0; z_w_in = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    checks++; if (op0 !== 16'h0) begin errors++; $display("FAIL reset_op0: got %h expected %h", op0, 16'h0); end
    checks++; if (op1 !== 16'h0) begin errors++; $display("FAIL reset_op1: got %h expected %h", op1, 16'h0); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b expected 0", op_valid); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h expected 00", pending); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    w_en = 1'b1; w_addr = 3'd3; w_in = 16'hBEEF;
    tick();
    w_addr = 3'd5; w_in = 16'h1234;
    tick();
    w_en = 1'b0; rd_en = 1'b1; rd0_addr = 3'd3; rd1_addr = 3'd5;
    tick();
    checks++; if (op0 !== 16'hBEEF) begin errors++; $display("FAIL rd_op0: got %h expected %h", op0, 16'hBEEF); end
    checks++; if (op1 !== 16'h1234) begin errors++; $display("FAIL rd_op1: got %h expected %h", op1, 16'h1234); end
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL rd_op_valid: got %b expected 1", op_valid); end
    // no request: data holds, valid drops
    rd_en = 1'b0;
    tick();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL idle_op_valid: got %b expected 0", op_valid); end
    checks++; if (op0 !== 16'hBEEF) begin errors++; $display("FAIL idle_op0_hold: got %h expected %h", op0, 16'hBEEF); end
  endtask

  task automatic test_forwarding();
    w_en = 1'b1; w_addr = 3'd2; w_in = 16'h0001;
    tick();
    w_in = 16'hA5A5; rd_en = 1'b1; rd0_addr = 3'd2; rd1_addr = 3'd2;
    tick();
    checks++; if (op0 !== 16'hA5A5) begin errors++; $display("FAIL fwd_op0: got %h expected %h", op0, 16'hA5A5); end
    checks++; if (op1 !== 16'hA5A5) begin errors++; $display("FAIL fwd_op1_same_reg: got %h expected %h", op1, 16'hA5A5); end
    w_en = 1'b0; rd0_addr = 3'd2; rd1_addr = 3'd3;
    tick();
    checks++; if (op0 !== 16'hA5A5) begin errors++; $display("FAIL fwd_stored_op0: got %h expected %h", op0, 16'hA5A5); end
    checks++; if (op1 !== 16'hBEEF) begin errors++; $display("FAIL fwd_stored_op1: got %h expected %h", op1, 16'hBEEF); end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_scoreboard();
    lock_en = 1'b1; lock_addr = 3'd4;
    tick();
    lock_en = 1'b0;
    checks++; if (pending !== 8'h10) begin errors++; $display("FAIL lock_pending: got %h expected %h", pending, 8'h10); end
    rd_en = 1'b1; rd0_addr = 3'd3; rd1_addr = 3'd4;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard: got %b expected 1", hazard); end
    tick();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL sb_op_valid: got %b expected 0", op_valid); end
    checks++; if (op0 !== 16'hA5A5) begin errors++; $display("FAIL sb_op0_hold: got %h expected %h", op0, 16'hA5A5); end
    checks++; if (op1 !== 16'hBEEF) begin errors++; $display("FAIL sb_op1_hold: got %h expected %h", op1, 16'hBEEF); end
    // a same-cycle write resolves the hazard
    w_en = 1'b1; w_addr = 3'd4; w_in = 16'h00FF;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_resolve_hazard: got %b expected 0", hazard); end
    tick();
    checks++; if (op1 !== 16'h00FF) begin errors++; $display("FAIL sb_resolve_op1: got %h expected %h", op1, 16'h00FF); end
    checks++; if (op0 !== 16'hBEEF) begin errors++; $display("FAIL sb_resolve_op0: got %h expected %h", op0, 16'hBEEF); end
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL sb_resolve_valid: got %b expected 1", op_valid); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL sb_resolve_pending: got %h expected 00", pending); end
    w_en = 1'b0; rd_en = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    w_en = 1'b1; w_addr = 3'd6; w_in = 16'h7777;
    lock_en = 1'b1; lock_addr = 3'd6;
    tick();
    w_en = 1'b0; lock_en = 1'b0;
    checks++; if (pending !== 8'h40) begin errors++; $display("FAIL coll_pending: got %h expected %h", pending, 8'h40); end
    checks++; if (dut.regs[6] !== 16'h7777) begin errors++; $display("FAIL coll_data: got %h expected %h", dut.regs[6], 16'h7777); end
    rd_en = 1'b1; rd0_addr = 3'd6; rd1_addr = 3'd0;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL coll_hazard_port0: got %b expected 1", hazard); end
    rd_en = 1'b0;
    // relocking an already pending register keeps it pending
    lock_en = 1'b1; lock_addr = 3'd6;
    tick();
    lock_en = 1'b0;
    checks++; if (pending !== 8'h40) begin errors++; $display("FAIL relock_pending: got %h expected %h", pending, 8'h40); end
  endtask

  task automatic test_async_reset();
    w_en = 1'b1; w_addr = 3'd7; w_in = 16'h1111;
    tick();
    w_en = 1'b0;
    rd_en = 1'b1; rd0_addr = 3'd7; rd1_addr = 3'd7;
    lock_en = 1'b1; lock_addr = 3'd1;
    tick();
    rd_en = 1'b0; lock_en = 1'b0;
    checks++; if (op0 !== 16'h1111) begin errors++; $display("FAIL pre_rst_op0: got %h expected %h", op0, 16'h1111); end
    checks++; if (pending !== 8'h42) begin errors++; $display("FAIL pre_rst_pending: got %h expected %h", pending, 8'h42); end
    // assert reset 3 ns after the edge; check 1 ns later, before the next edge
    #2;
    reset = 1'b1;
    #1;
    checks++; if (op0 !== 16'h0) begin errors++; $display("FAIL async_rst_op0: got %h expected 0000", op0); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL async_rst_op_valid: got %b expected 0", op_valid); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL async_rst_pending: got %h expected 00", pending); end
    rd_en = 1'b1; rd0_addr = 3'd1; rd1_addr = 3'd6;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL async_rst_hazard: got %b expected 0", hazard); end
    rd_en = 1'b0;
    tick();
    reset = 1'b0;
    rd_en = 1'b1; rd0_addr = 3'd7; rd1_addr = 3'd6;
    tick();
    rd_en = 1'b0;
    checks++; if (op0 !== 16'h0) begin errors++; $display("FAIL post_rst_reg7: got %h expected 0000", op0); end
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b expected 1", op_valid); end
  endtask

  task automatic test_zero_reg();
    z_w_en = 1'b1; z_w_addr = 3'd1; z_w_in = 16'h1357;
    tick();
    // write and lock r0: both dropped
    z_w_addr = 3'd0; z_w_in = 16'hFFFF;
    z_lock_en = 1'b1; z_lock_addr = 3'd0;
    tick();
    checks++; if (z_pending !== 6'h00) begin errors++; $display("FAIL zero_lock_pending: got %h expected 00", z_pending); end
    // read r0 with a same-cycle write to it, and out-of-range address 7
    z_lock_addr = 3'd7;
    z_rd_en = 1'b1; z_rd0_addr = 3'd0; z_rd1_addr = 3'd7;
    #1;
    checks++; if (z_hazard !== 1'b0) begin errors++; $display("FAIL zero_hazard: got %b expected 0", z_hazard); end
    tick();
    z_lock_en = 1'b0;
    checks++; if (z_op0 !== 16'h0) begin errors++; $display("FAIL zero_op0: got %h expected 0000", z_op0); end
    checks++; if (z_op1 !== 16'h0) begin errors++; $display("FAIL oob_op1: got %h expected 0000", z_op1); end
    checks++; if (z_op_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", z_op_valid); end
    checks++; if (z_pending !== 6'h00) begin errors++; $display("FAIL oob_lock_pending: got %h expected 00", z_pending); end
    // write to address 6 (>= DEPTH) is dropped and not forwarded
    z_w_addr = 3'd6; z_w_in = 16'hABCD;
    z_rd0_addr = 3'd6; z_rd1_addr = 3'd1;
    tick();
    z_w_en = 1'b0;
    checks++; if (z_op0 !== 16'h0) begin errors++; $display("FAIL oob_write_fwd: got %h expected 0000", z_op0); end
    checks++; if (z_op1 !== 16'h1357) begin errors++; $display("FAIL zero_r1: got %h expected %h", z_op1, 16'h1357); end
    z_rd_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_forwarding();
    test_scoreboard();
    test_collision();
    test_async_reset();
    test_zero_reg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised 2-read/1-write register file with a per-register pending-write scoreboard. It replaces the fixed 8x16 register file in the datapath, and takes read and write addresses on separate ports. Read outputs are registered, with write-to-read forwarding. A scoreboard tracks registers awaiting a multi-cycle result (e.g. a memory load) and flags read hazards to the control unit.

Parameters:
WIDTH, 16, data width of each register and of every data port
DEPTH, 8, number of architectural registers (2..2^ADDR_W)
ADDR_W, 3, address width; elaboration must fail if 2^ADDR_W < DEPTH
ZERO_REG, 0, 1 = register 0 is hardwired to zero (writes and locks to it are ignored)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
w_en  input  1  write enable
w_addr  input  ADDR_W  write destination
w_in  input  WIDTH  write data
rd_en  input  1  read request; sample both read ports this cycle
rd0_addr  input  ADDR_W  read port 0 source
rd1_addr  input  ADDR_W  read port 1 source
lock_en  input  1  mark lock_addr as pending (result in flight)
lock_addr  input  ADDR_W  register to lock
op0  output  WIDTH  registered read data, port 0
op1  output  WIDTH  registered read data, port 1
op_valid  output  1  registered; op0/op1 were updated by a hazard-free read on the previous edge
hazard  output  1  combinational; current read request hits a pending register
pending  output  DEPTH  scoreboard bit vector, bit i = register i pending

Behaviour:
- Reset (async, any time, including mid-lock): all registers, op0, op1, op_valid and pending clear to 0 immediately. hazard then evaluates to 0.
- Address is "legal" if < DEPTH and not (ZERO_REG and addr==0).
- Write: on a rising edge with w_en and legal w_addr, reg[w_addr] <= w_in and pending[w_addr] <= 0. Writes to illegal addresses are dropped.
- Lock: on a rising edge with lock_en and legal lock_addr, pending[lock_addr] <= 1.
  - Lock and write to the same address on the same edge: lock wins, so the pending bit ends at 1 and the data is still written.
  - Locking an already-pending register keeps it at 1.
- Read value for port k is determined in this priority order:
  1. Address >= DEPTH: 0.
  2. ZERO_REG and address==0: 0.
  3. w_en and w_addr==rdk_addr (legal): w_in (forwarding).
  4. Otherwise: reg[rdk_addr].
- hazard = rd_en AND (hz0 OR hz1). hzk = pending[rdk_addr] AND NOT (w_en AND w_addr==rdk_addr). A same-cycle write resolves the hazard; illegal addresses never hazard.
- Rising edge with rd_en and not hazard: op0/op1 load their read values and op_valid <= 1. Latency is one cycle from address to data.
- Rising edge with rd_en and hazard, or with rd_en=0: op0/op1 hold and op_valid <= 0.
- Both ports may address the same register; both return the same value.
- No internal state machine beyond the register array, the scoreboard and the output registers. Scoreboard bits persist until written or reset; no timeout.

Test Plan:
- Reset then read: after reset, write 0xBEEF to r3 and 0x1234 to r5. Next cycle, rd_en with rd0=3, rd1=5 -> after one edge op0=0xBEEF, op1=0x1234, op_valid=1.
- Forwarding: r2=0x0001; same cycle w_en w_addr=2 w_in=0xA5A5 and rd0=2 -> op0=0xA5A5 after the edge; reg r2 reads 0xA5A5 thereafter.
- Scoreboard: lock r4; next cycle read rd1=4 -> hazard=1, op_valid=0 after the edge, op0/op1 unchanged. Then write r4=0x00FF with rd1=4 in the same cycle -> hazard=0, op1=0x00FF, pending[4]=0.
- Lock/write collision: lock_addr=w_addr=6 on the same edge with w_in=0x7777 -> pending[6]=1 and reg r6=0x7777. A following read of r6 without a write -> hazard=1.
- ZERO_REG=1, DEPTH=6: write 0xFFFF to r0 and lock r0 -> op reads 0, pending[0]=0. Read address 7 -> 0, no hazard. Write to address 6 is ignored.
- Async reset mid-operation: with r1 pending and op0=0x1111, assert reset between clock edges -> op0=0, op_valid=0 and pending=0 before the next edge.
